// File: rtl/write_sequencer_if.sv
// Bus bundle for write_sequencer: command, data stream,
// single-beat write port and sequence status.
interface write_sequencer_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int CNT_WDTH  = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_WDTH-1:0] cmd_base_addr;
  logic [CNT_WDTH-1:0]  cmd_count;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_WDTH-1:0] s_data;
  logic                 wr_start;
  logic [ADDR_WDTH-1:0] wr_addr;
  logic [DATA_WDTH-1:0] wr_data;
  logic                 wr_done;
  logic [RESP_WDTH-1:0] wr_resp;
  logic                 busy;
  logic                 seq_done;
  logic                 seq_err;
  logic [CNT_WDTH-1:0]  err_count;

  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_count,
    input  s_valid, s_data, wr_done, wr_resp,
    output cmd_ready, s_ready, wr_start, wr_addr,
    output wr_data, busy, seq_done, seq_err,
    output err_count
  );

  modport master (
    output cmd_valid, cmd_base_addr, cmd_count,
    output s_valid, s_data, wr_done, wr_resp,
    input  cmd_ready, s_ready, wr_start, wr_addr,
    input  wr_data, busy, seq_done, seq_err,
    input  err_count
  );
endinterface

// File: rtl/write_sequencer.sv
// Buffers a counted data burst and replays it word by
// word into a single-beat write submodule.
module write_sequencer #(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WDTH   = 4
) (
  input logic              clk,
  input logic              rst_n,
  write_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC =
    OCC_W'(FIFO_DEPTH);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOAD        = 3'd1;
  localparam logic [2:0] ISSUE       = 3'd2;
  localparam logic [2:0] WAIT_ACCEPT = 3'd3;
  localparam logic [2:0] WAIT_RESP   = 3'd4;
  localparam logic [2:0] FINISH      = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_WDTH-1:0] addr_q;
  logic [ADDR_WDTH-1:0] wr_addr_q;
  logic [DATA_WDTH-1:0] wr_data_q;
  logic [CNT_WDTH-1:0]  acc_left_q;
  logic [CNT_WDTH-1:0]  iss_left_q;
  logic [CNT_WDTH-1:0]  err_cnt_q;
  logic                 seq_err_q;
  logic [DATA_WDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]     occ_q;

  logic cmd_hs, busy, full, empty;
  logic s_ready, push, pop, resp_fire;

  assign busy      = state_q != IDLE;
  assign cmd_hs    = bus.cmd_valid & ~busy;
  assign full      = occ_q == FULL_OCC;
  assign empty     = occ_q == '0;
  assign s_ready   = busy & (acc_left_q != '0) & ~full;
  assign push      = bus.s_valid & s_ready;
  assign pop       = (state_q == LOAD) & ~empty;
  assign resp_fire = (state_q == WAIT_RESP) & bus.wr_done;

  assign bus.cmd_ready = ~busy;
  assign bus.s_ready   = s_ready;
  assign bus.wr_start  = (state_q == ISSUE) & bus.wr_done;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy;
  assign bus.seq_done  = state_q == FINISH;
  assign bus.seq_err   = seq_err_q;
  assign bus.err_count = err_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (cmd_hs)
          state_d = (bus.cmd_count == '0) ? FINISH : LOAD;
      LOAD:
        if (!empty) state_d = ISSUE;
      ISSUE:
        if (bus.wr_done) state_d = WAIT_ACCEPT;
      WAIT_ACCEPT:
        if (!bus.wr_done) state_d = WAIT_RESP;
      WAIT_RESP:
        if (bus.wr_done)
          state_d = (iss_left_q == CNT_WDTH'(1)) ?
                    FINISH : LOAD;
      FINISH:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      acc_left_q <= '0;
      iss_left_q <= '0;
      err_cnt_q  <= '0;
      seq_err_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        addr_q     <= bus.cmd_base_addr;
        acc_left_q <= bus.cmd_count;
        iss_left_q <= bus.cmd_count;
        err_cnt_q  <= '0;
        seq_err_q  <= 1'b0;
      end else begin
        if (push)
          acc_left_q <= acc_left_q - CNT_WDTH'(1);
        if (resp_fire) begin
          addr_q     <= addr_q + ADDR_WDTH'(1);
          iss_left_q <= iss_left_q - CNT_WDTH'(1);
          if (bus.wr_resp != '0) begin
            seq_err_q <= 1'b1;
            if (err_cnt_q != '1)
              err_cnt_q <= err_cnt_q + CNT_WDTH'(1);
          end
        end
      end
      if (pop) begin
        wr_data_q <= mem_q[rd_ptr_q];
        wr_addr_q <= addr_q;
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
      end
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (push && !pop)
        occ_q <= occ_q + OCC_W'(1);
      else if (pop && !push)
        occ_q <= occ_q - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_write_sequencer.sv
// Scoreboard bench for write_sequencer with a behavioural
// write-submodule model and randomized bursts.
module tb_write_sequencer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;
  localparam int FD = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  write_sequencer_if #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW),
    .RESP_WDTH(RW), .CNT_WDTH(CW)
  ) bus ();

  write_sequencer #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW),
    .FIFO_DEPTH(FD), .CNT_WDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic          e;
    logic [CW-1:0] c;
  } done_t;

  wr_t           exp_wr[$];
  done_t         exp_done[$];
  logic [RW-1:0] resp_q[$];
  logic [DW-1:0] data_q[$];
  logic [DW-1:0] stim_d[$];
  logic [RW-1:0] stim_r[$];

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int n_starts = 0;
  bit bp_seen = 1'b0;
  bit gap_en = 1'b0;
  bit abort = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitor
  initial begin
    wr_t   w;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wr_start) begin
          n_starts++;
          if (exp_wr.size() == 0) begin
            fail("unexpected_wr_start");
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 64'(bus.wr_addr), 64'(w.a));
            chk("wr_data", 64'(bus.wr_data), 64'(w.d));
          end
        end
        if (bus.seq_done) begin
          if (exp_done.size() == 0) begin
            fail("unexpected_seq_done");
          end else begin
            d = exp_done.pop_front();
            chk("seq_err", 64'(bus.seq_err), 64'(d.e));
            chk("err_count", 64'(bus.err_count),
                64'(d.c));
            chk("writes_left", 64'(exp_wr.size()), 64'd0);
          end
        end
        if (bus.busy && bus.s_valid && !bus.s_ready)
          bp_seen = 1'b1;
      end
    end
  end

  // Write submodule model: idle-high done, configurable latency
  initial begin
    int            m_st;
    int            m_cnt;
    logic [RW-1:0] m_resp;
    m_st = 0;
    m_cnt = 0;
    m_resp = '0;
    bus.wr_done = 1'b1;
    bus.wr_resp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_st = 0;
        bus.wr_done = 1'b1;
        bus.wr_resp = '0;
      end else begin
        case (m_st)
          0: if (bus.wr_start) begin
               m_resp = (resp_q.size() != 0) ?
                        resp_q.pop_front() : '0;
               m_st = 1;
             end
          1: begin
               bus.wr_done = 1'b0;
               m_cnt = lat;
               m_st = 2;
             end
          default: begin
               m_cnt--;
               if (m_cnt <= 0) begin
                 bus.wr_done = 1'b1;
                 bus.wr_resp = m_resp;
                 m_st = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_wr_start", 64'(bus.wr_start), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_seq_done", 64'(bus.seq_done), 64'd0);
    chk("rst_seq_err", 64'(bus.seq_err), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
  endtask

  task automatic flush();
    exp_wr.delete();
    exp_done.delete();
    resp_q.delete();
    data_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.cmd_valid = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_rand(input int n, input int pct);
    stim_d.delete();
    stim_r.delete();
    for (int i = 0; i < n; i++) begin
      stim_d.push_back($urandom);
      stim_r.push_back(
        RW'($urandom_range(99) < pct ? 1 : 0));
    end
  endtask

  task automatic prepare(input logic [AW-1:0] base);
    int errs = 0;
    for (int i = 0; i < stim_d.size(); i++) begin
      exp_wr.push_back('{a: base + AW'(i), d: stim_d[i]});
      resp_q.push_back(stim_r[i]);
      if (stim_r[i] != '0) errs++;
    end
    exp_done.push_back('{e: (errs != 0),
                         c: CW'(errs > 15 ? 15 : errs)});
    data_q = stim_d;
  endtask

  task automatic issue_cmd(input logic [AW-1:0] base,
                           input int n);
    @(negedge clk);
    chk("cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_base_addr = base;
    bus.cmd_count = CW'(n);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input int budget);
    int k = 0;
    while (data_q.size() != 0 && !abort && k < budget) begin
      bus.s_valid = gap_en ? ($urandom_range(3) != 0) : 1'b1;
      bus.s_data = data_q[0];
      if (bus.s_valid && bus.s_ready)
        void'(data_q.pop_front());
      @(negedge clk);
      k++;
    end
    bus.s_valid = 1'b0;
    if (k >= budget) fail("feed_timeout");
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_done.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (exp_done.size() != 0) begin
      fail("seq_done_timeout");
      do_reset();
    end
  endtask

  task automatic run_seq(input logic [AW-1:0] base,
                         input int l);
    lat = l;
    prepare(base);
    issue_cmd(base, stim_d.size());
    feed(5000);
    wait_done(3000);
  endtask

  initial begin
    int s0;
    int k;
    bus.cmd_valid = 1'b0;
    bus.cmd_base_addr = '0;
    bus.cmd_count = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_vals();
    repeat (20) @(negedge clk);

    // Single word
    stim_d = '{32'hDEADBEEF};
    stim_r = '{1'b0};
    run_seq(4'h3, 2);

    // Address wrap with alternating errors
    stim_d = '{32'd1, 32'd2, 32'd3, 32'd4};
    stim_r = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_seq(4'hE, 1);

    // Backpressure: slow writes, FIFO fills
    bp_seen = 1'b0;
    fill_rand(6, 0);
    run_seq(4'h5, 10);
    chk("backpressure_seen", 64'(bp_seen), 64'd1);

    // Zero count with data offered
    exp_done.push_back('{e: 1'b0, c: '0});
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_base_addr = 4'h9;
    bus.cmd_count = '0;
    bus.s_valid = 1'b1;
    bus.s_data = 32'hBAD0BAD0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("zero_s_ready_a", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("zero_done_timing", 64'(exp_done.size()), 64'd0);
    chk("zero_s_ready_b", 64'(bus.s_ready), 64'd0);
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b0;
    wait_done(10);

    // Randomized bursts
    gap_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      fill_rand($urandom_range(15), $urandom_range(100));
      run_seq(AW'($urandom), $urandom_range(1, 4));
    end
    fill_rand(15, 100);
    run_seq(4'h0, 1);
    gap_en = 1'b0;

    // Reset in the middle of a sequence
    fill_rand(5, 100);
    lat = 3;
    prepare(4'h2);
    s0 = n_starts;
    issue_cmd(4'h2, 5);
    abort = 1'b0;
    fork
      feed(5000);
    join_none
    k = 0;
    while (n_starts < s0 + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) fail("mid_reset_wait");
    @(negedge clk);
    rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    flush();
    bus.s_valid = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("post_rst_idle", 64'(bus.busy), 64'd0);

    stim_d = '{32'h0BADF00D};
    stim_r = '{1'b0};
    run_seq(4'h7, 2);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

endmodule
